// File: rtl/apb_requester.sv
// Single-outstanding APB3 initiator: valid/ready commands in, one response out.
// Adds wait-state handling and a PREADY timeout so a dead slave cannot hang it.
module apb_requester #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // One extra bit keeps the counter alive when the timeout is disabled
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  psel_nxt, pen_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  rvalid_nxt, rwrite_nxt, rto_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  expire;

    assign cmd_ready = (state == IDLE);
    assign expire = (TIMEOUT != 0) && (cnt == TO_LIM - CW'(1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            PSELx       <= psel_nxt;
            PENABLE     <= pen_nxt;
            PWRITE      <= pwrite_nxt;
            PADDR       <= paddr_nxt;
            PWDATA      <= pwdata_nxt;
            rsp_valid   <= rvalid_nxt;
            rsp_write   <= rwrite_nxt;
            rsp_rdata   <= rdata_nxt;
            rsp_timeout <= rto_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        psel_nxt   = 1'b0;
        pen_nxt    = 1'b0;
        pwrite_nxt = PWRITE;
        paddr_nxt  = PADDR;
        pwdata_nxt = PWDATA;
        rvalid_nxt = 1'b0;
        rwrite_nxt = rsp_write;
        rdata_nxt  = rsp_rdata;
        rto_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = '0;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
                psel_nxt  = 1'b1;
                pen_nxt   = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_nxt  = IDLE;
                    rvalid_nxt = 1'b1;
                    rwrite_nxt = PWRITE;
                    rdata_nxt  = PWRITE ? '0 : PRDATA;
                end else begin
                    if (cnt != '1)
                        cnt_nxt = cnt + CW'(1);
                    if (expire) begin
                        state_nxt  = IDLE;
                        rvalid_nxt = 1'b1;
                        rwrite_nxt = PWRITE;
                        rdata_nxt  = '0;
                        rto_nxt    = 1'b1;
                    end else begin
                        psel_nxt = 1'b1;
                        pen_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester (TIMEOUT=4): reset, waits, timeout,
// back-to-back and mid-transfer reset.
module tb_apb_requester;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid, rsp_write, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       PSELx, PENABLE, PWRITE;
    logic [6:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = '0;
    logic       PREADY = 1'b0;

    int total = 0;
    int passed = 0;
    int pen_cnt;

    apb_requester #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus(input string tag, input logic s, input logic e);
        chk({tag, "_psel"}, 32'(PSELx), 32'(s));
        chk({tag, "_pen"}, 32'(PENABLE), 32'(e));
    endtask

    task automatic rsp(input string tag, input logic v, input logic w,
                       input logic [7:0] d, input logic t);
        chk({tag, "_rv"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_rw"}, 32'(rsp_write), 32'(w));
        chk({tag, "_rd"}, 32'(rsp_rdata), 32'(d));
        chk({tag, "_rto"}, 32'(rsp_timeout), 32'(t));
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 PRESETn = 1'b0;
        #2;
        bus("rst", 1'b0, 1'b0);
        rsp("rst", 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", 32'(PWDATA), 32'd0);
        #9 PRESETn = 1'b1;
        #1 chk("rst_ready", 32'(cmd_ready), 32'd1);

        // write 0x55 to 0x0F, zero wait states
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 7'h0F; cmd_wdata = 8'h55; PREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        bus("w0_setup", 1'b1, 1'b0);
        chk("w0_ready", 32'(cmd_ready), 32'd0);
        chk("w0_paddr", 32'(PADDR), 32'h0F);
        chk("w0_pwdata", 32'(PWDATA), 32'h55);
        chk("w0_pwrite", 32'(PWRITE), 32'd1);
        tick();
        bus("w0_access", 1'b1, 1'b1);
        tick();
        bus("w0_done", 1'b0, 1'b0);
        rsp("w0", 1'b1, 1'b1, 8'h00, 1'b0);
        chk("w0_ready2", 32'(cmd_ready), 32'd1);
        tick();
        chk("w0_pulse", 32'(rsp_valid), 32'd0);
        chk("w0_hold_rw", 32'(rsp_write), 32'd1);
        chk("w0_keep_paddr", 32'(PADDR), 32'h0F);

        // read 0x4C with two wait states
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h4C;
        cmd_wdata = 8'h99; PREADY = 1'b0; PRDATA = 8'hAA;
        tick();
        cmd_valid = 1'b0;
        bus("r2_setup", 1'b1, 1'b0);
        tick();
        bus("r2_acc1", 1'b1, 1'b1);
        tick();
        bus("r2_acc2", 1'b1, 1'b1);
        chk("r2_paddr", 32'(PADDR), 32'h4C);
        chk("r2_pwrite", 32'(PWRITE), 32'd0);
        tick();
        bus("r2_acc3", 1'b1, 1'b1);
        chk("r2_rv_wait", 32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        tick();
        bus("r2_done", 1'b0, 1'b0);
        rsp("r2", 1'b1, 1'b0, 8'hAA, 1'b0);
        tick();

        // timeout: PREADY stuck low
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h4C;
        PREADY = 1'b0; PRDATA = 8'h33;
        tick();
        cmd_valid = 1'b0;
        bus("to_setup", 1'b1, 1'b0);
        pen_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) break;
            if (PENABLE) pen_cnt++;
        end
        chk("to_access_cycles", 32'(pen_cnt), 32'd4);
        bus("to_released", 1'b0, 1'b0);
        rsp("to", 1'b1, 1'b0, 8'h00, 1'b1);
        chk("to_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("to_pulse_rv", 32'(rsp_valid), 32'd0);
        chk("to_pulse_rto", 32'(rsp_timeout), 32'd0);

        // back-to-back: write 0xF5 to 0x0F, then read 0x4C
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h0F;
        cmd_wdata = 8'hF5; PREADY = 1'b1; PRDATA = 8'hFA;
        tick();
        bus("bb1_setup", 1'b1, 1'b0);
        chk("bb1_pwdata", 32'(PWDATA), 32'hF5);
        cmd_write = 1'b0; cmd_addr = 7'h4C;
        tick();
        bus("bb1_access", 1'b1, 1'b1);
        tick();
        bus("bb_gap", 1'b0, 1'b0);
        rsp("bb1", 1'b1, 1'b1, 8'h00, 1'b0);
        chk("bb_gap_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        bus("bb2_setup", 1'b1, 1'b0);
        chk("bb2_paddr", 32'(PADDR), 32'h4C);
        chk("bb2_pwrite", 32'(PWRITE), 32'd0);
        chk("bb2_rv_low", 32'(rsp_valid), 32'd0);
        tick();
        bus("bb2_access", 1'b1, 1'b1);
        tick();
        rsp("bb2", 1'b1, 1'b0, 8'hFA, 1'b0);
        tick();

        // reset in the middle of a wait state
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h4C;
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        bus("mr_wait", 1'b1, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        bus("mr_async", 1'b0, 1'b0);
        chk("mr_rv", 32'(rsp_valid), 32'd0);
        chk("mr_paddr", 32'(PADDR), 32'd0);
        PREADY = 1'b1;
        tick();
        #3 PRESETn = 1'b1;
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        tick();
        bus("mr_after", 1'b0, 1'b0);
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("mr_no_rsp2", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
# apb_requester

Single-outstanding APB initiator that turns a simple valid/ready command interface into APB3 SETUP/ACCESS transfers and returns one response per command. It drives APB-slave FIFO bridges such as the TX/RX FIFO interface from on-chip logic, replacing hand-driven bus sequences. It adds wait-state handling and a PREADY timeout so a dead slave cannot hang the requester.

## Interface
- ADDR_WIDTH, 7, width of PADDR and cmd_addr
- DATA_WIDTH, 8, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  requester can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_timeout  out  1  transfer aborted by timeout
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB slave ready

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1 (combinational from state only). On cmd_valid&&cmd_ready, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
- SETUP: PSELx=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - PREADY=1 at edge: complete; capture PRDATA into rsp_rdata if read, else rsp_rdata=0; go IDLE.
  - PREADY=0: increment wait counter; if TIMEOUT!=0 and counter reaches TIMEOUT, abort: rsp_timeout=1, rsp_rdata=0, go IDLE.
  - PREADY=1 on same edge the counter would reach TIMEOUT: completion wins, no timeout.
- Wait counter cleared on entry to SETUP; width clog2(TIMEOUT+1), never wraps.
- Only one transfer outstanding; no pipelining; no response backpressure (consumer must accept rsp_valid every cycle).
- All outputs except cmd_ready are registered.
- PADDR/PWDATA/PWRITE keep last transfer values in IDLE; PSELx=PENABLE=0 in IDLE.

## Timing
- Reset (async, immediate): state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_timeout=0, counter=0; cmd_ready=1 after reset release.
- Accept at edge N -> PSELx=1 from N+1 (SETUP) -> PENABLE=1 from N+2 (ACCESS).
- Zero wait states: completion edge N+3; PSELx/PENABLE=0 and rsp_valid=1 during N+3..N+4; cmd_ready=1 again in same cycle.
- W wait states: completion edge N+3+W; rsp_valid one cycle after it.
- Timeout: TIMEOUT cycles of ACCESS with PREADY low; abort edge N+2+TIMEOUT; rsp_valid+rsp_timeout the next cycle.
- rsp_valid, rsp_timeout high exactly one cycle; rsp_write/rsp_rdata valid with rsp_valid, held until next response.
- Back-to-back: new command accepted in response cycle; min 3 cycles per transfer.
- Reset mid-transfer: bus deasserted immediately, no response issued, pending command discarded.

## Test plan
- Reset: assert PRESETn=0 mid-run -> all outputs 0 immediately, cmd_ready=1 after release.
- Write 0 waits: cmd write addr 0x0F data 0x55, PREADY=1 -> PSELx 2 cycles, PENABLE 1 cycle, PADDR=0x0F, PWDATA=0x55, PWRITE=1; rsp_valid=1, rsp_write=1, rsp_rdata=0, rsp_timeout=0.
- Read 2 waits: cmd read addr 0x4C, PREADY low 2 ACCESS cycles then high with PRDATA=0xAA -> PENABLE 3 cycles, signals stable, rsp_rdata=0xAA.
- Timeout (TIMEOUT=4): read addr 0x4C, PREADY held 0 -> exactly 4 ACCESS cycles, bus released, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
- Back-to-back: cmd_valid held with write 0xF5 to 0x0F then read 0x4C (PRDATA=0xFA), PREADY=1 -> transfers 3 cycles apart, responses 0x00 then 0xFA, PSELx low 1 cycle between.
- Reset mid-ACCESS: assert reset during wait state -> PSELx/PENABLE drop asynchronously, no rsp_valid.
